interrupt_sequencer: RTL and testbench

Multi-cycle controller that sequences interrupt entry for the decode stage's control unit. It latches external interrupt requests and waits for a safe pipeline point, with no control transfer or memory op in flight. It then drives the decode stage's interrupt input for the PC-push and flags-push micro-ops, loads the interrupt vector, stalls and flushes fetch, and blocks nesting until RTI retires.

---
 rtl/interrupt_sequencer.sv | 79 +++++++
 tb/tb_interrupt_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: latches interrupt requests and sequences push-PC, push-flags, vector load and fetch drain.
module interrupt_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_int_req,
  input  logic       i_branch_busy,
  input  logic       i_mem_busy,
  input  logic       i_rti_done,
  output logic       o_interrupt,
  output logic       o_stall_fetch,
  output logic       o_flush_fetch,
  output logic       o_load_vector,
  output logic       o_in_isr,
  output logic       o_pending,
  output logic [2:0] o_state
);
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT       = 3'd1,
    ST_PUSH_PC    = 3'd2,
    ST_PUSH_FLAGS = 3'd3,
    ST_VECTOR     = 3'd4,
    ST_DRAIN      = 3'd5
  } state_e;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);
  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic             in_isr_q, in_isr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             done_next;
  always_comb begin
    accept    = pending_q & ~in_isr_q & ~i_branch_busy & ~i_mem_busy;
    pending_d = (pending_q | i_int_req) & ~((state_q == ST_WAIT) & accept);
    // VECTOR sets in_isr and wins over a coincident rti_done
    in_isr_d  = (state_q == ST_VECTOR) | (in_isr_q & ~i_rti_done);
    done_next = pending_d;
    cnt_d     = cnt_q;
    state_d   = ST_IDLE;
    case (state_q)
      ST_IDLE:       state_d = i_int_req ? ST_WAIT : ST_IDLE;
      ST_WAIT:       state_d = accept ? ST_PUSH_PC : ST_WAIT;
      ST_PUSH_PC:    state_d = ST_PUSH_FLAGS;
      ST_PUSH_FLAGS: state_d = ST_VECTOR;
      ST_VECTOR: begin
        cnt_d   = CNT_LOAD;
        state_d = (DRAIN_CYCLES > 0) ? ST_DRAIN : (done_next ? ST_WAIT : ST_IDLE);
      end
      ST_DRAIN: begin
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        state_d = (cnt_q != '0) ? ST_DRAIN : (done_next ? ST_WAIT : ST_IDLE);
      end
      default:       state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      in_isr_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      in_isr_q  <= in_isr_d;
      cnt_q     <= cnt_d;
    end
  end
  assign o_interrupt   = (state_q == ST_PUSH_PC) | (state_q == ST_PUSH_FLAGS);
  assign o_stall_fetch = o_interrupt | (state_q == ST_DRAIN);
  assign o_flush_fetch = (state_q == ST_PUSH_PC) | (state_q == ST_VECTOR);
  assign o_load_vector = (state_q == ST_VECTOR);
  assign o_in_isr      = in_isr_q;
  assign o_pending     = pending_q;
  assign o_state       = state_q;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed and random checks of two builds (DRAIN_CYCLES=3 and 0) against a sequence-position model.
module tb_interrupt_sequencer;
  logic i_clk = 1'b0;
  logic i_reset = 1'b0, i_int_req = 1'b0, i_branch_busy = 1'b0, i_mem_busy = 1'b0, i_rti_done = 1'b0;
  logic o_int[2], o_stall[2], o_flush[2], o_load[2], o_isr[2], o_pend[2];
  logic [2:0] o_st[2];
  int tests = 0, fails = 0;
  int pos[2], dcyc[2];
  bit waiting[2], pending[2], in_isr[2];
  always #5 i_clk = ~i_clk;
  interrupt_sequencer #(.DRAIN_CYCLES(3), .CNT_W(3)) u_d3 (
    .i_clk(i_clk), .i_reset(i_reset), .i_int_req(i_int_req), .i_branch_busy(i_branch_busy),
    .i_mem_busy(i_mem_busy), .i_rti_done(i_rti_done), .o_interrupt(o_int[0]), .o_stall_fetch(o_stall[0]),
    .o_flush_fetch(o_flush[0]), .o_load_vector(o_load[0]), .o_in_isr(o_isr[0]), .o_pending(o_pend[0]),
    .o_state(o_st[0]));
  interrupt_sequencer #(.DRAIN_CYCLES(0), .CNT_W(3)) u_d0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_int_req(i_int_req), .i_branch_busy(i_branch_busy),
    .i_mem_busy(i_mem_busy), .i_rti_done(i_rti_done), .o_interrupt(o_int[1]), .o_stall_fetch(o_stall[1]),
    .o_flush_fetch(o_flush[1]), .o_load_vector(o_load[1]), .o_in_isr(o_isr[1]), .o_pending(o_pend[1]),
    .o_state(o_st[1]));
  task automatic chk(input string tag, input int idx, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s[d%0d]: got %0h expected %0h", tag, dcyc[idx], got, exp);
    end
  endtask
  // pos counts cycles into a committed sequence: 0 push-PC, 1 push-flags, 2 vector, 3.. drain
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit acc, np, ni;
      if (i_reset) begin
        pos[i] = -1; waiting[i] = 0; pending[i] = 0; in_isr[i] = 0;
      end else begin
        acc = waiting[i] && pending[i] && !in_isr[i] && !i_branch_busy && !i_mem_busy;
        np  = (pending[i] || i_int_req) && !acc;
        ni  = (pos[i] == 2) || (in_isr[i] && !i_rti_done);
        if (pos[i] >= 0) begin
          pos[i]++;
          if (pos[i] == 3 + dcyc[i]) begin pos[i] = -1; waiting[i] = np; end
        end else if (waiting[i]) begin
          if (acc) begin pos[i] = 0; waiting[i] = 0; end
        end else if (i_int_req) waiting[i] = 1;
        pending[i] = np; in_isr[i] = ni;
      end
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int p, es;
      p  = pos[i];
      es = p < 0 ? (waiting[i] ? 1 : 0) : p == 0 ? 2 : p == 1 ? 3 : p == 2 ? 4 : 5;
      chk("state", i, {5'd0, o_st[i]}, 8'(es));
      chk("interrupt", i, {7'd0, o_int[i]}, 8'(p == 0 || p == 1));
      chk("stall", i, {7'd0, o_stall[i]}, 8'(p == 0 || p == 1 || p >= 3));
      chk("flush", i, {7'd0, o_flush[i]}, 8'(p == 0 || p == 2));
      chk("load_vector", i, {7'd0, o_load[i]}, 8'(p == 2));
      chk("in_isr", i, {7'd0, o_isr[i]}, 8'(in_isr[i]));
      chk("pending", i, {7'd0, o_pend[i]}, 8'(pending[i]));
    end
  endtask
  task automatic cyc(input bit req, input bit br, input bit mem, input bit rti, input bit rst);
    i_int_req = req; i_branch_busy = br; i_mem_busy = mem; i_rti_done = rti; i_reset = rst;
    @(posedge i_clk);
    model_step();
    #1;
    check_all();
  endtask
  initial begin
    int n_int, n_load, n_stall;
    logic [2:0] seen[8];
    logic [2:0] exp_seq[8];
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd0};
    dcyc[0] = 3; dcyc[1] = 0;
    for (int i = 0; i < 2; i++) begin pos[i] = -1; waiting[i] = 0; pending[i] = 0; in_isr[i] = 0; end
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset_state", 0, {5'd0, o_st[0]}, 8'd0);
    // single-cycle request on an idle pipeline
    n_int = 0; n_load = 0; n_stall = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(k == 0, 0, 0, 0, 0);
      seen[k] = o_st[0];
      n_int += int'(o_int[0]); n_load += int'(o_load[0]); n_stall += int'(o_stall[0]);
    end
    for (int k = 0; k < 8; k++) chk("seq_state", 0, {5'd0, seen[k]}, {5'd0, exp_seq[k]});
    chk("int_cycles", 0, 8'(n_int), 8'd2);
    chk("load_cycles", 0, 8'(n_load), 8'd1);
    chk("stall_cycles", 0, 8'(n_stall), 8'd5);
    chk("isr_after", 0, {7'd0, o_isr[0]}, 8'd1);
    cyc(0, 0, 0, 1, 0);
    // branch busy then memory busy holding WAIT
    for (int pass = 0; pass < 2; pass++) begin
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) cyc(0, pass == 0, pass == 1, 0, 0);
      chk("busy_wait", 0, {5'd0, o_st[0]}, 8'd1);
      cyc(0, 0, 0, 0, 0);
      chk("after_busy", 0, {5'd0, o_st[0]}, 8'd2);
      for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
    end
    // second request during ISR, rti on the VECTOR cycle, then release
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("rti_on_vector", 0, {7'd0, o_isr[0]}, 8'd1);
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0);
    chk("parked_wait", 0, {5'd0, o_st[0]}, 8'd1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("resume_push", 0, {5'd0, o_st[0]}, 8'd2);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    // request on accept cycle absorbed; request in PUSH_PC stays pending
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("pushpc_req_pending", 0, {7'd0, o_pend[0]}, 8'd1);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0);
    chk("back_to_wait", 0, {5'd0, o_st[0]}, 8'd1);
    cyc(0, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    // reset during PUSH_FLAGS
    cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    chk("in_push_flags", 0, {5'd0, o_st[0]}, 8'd3);
    cyc(0, 0, 0, 0, 1);
    chk("rst_state", 0, {5'd0, o_st[0]}, 8'd0);
    chk("rst_pending", 0, {7'd0, o_pend[0]}, 8'd0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0);
    // random traffic
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(7) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
          $urandom_range(11) == 0, $urandom_range(299) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
